// File: rtl/mem_port_master.sv
// Single-port memory master. Requests are registered onto the port, and reads are
// tracked through a two-stage pipe into a response FIFO. The FIFO space is reserved at accept.
module mem_port_master #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 64,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   input  logic [DATA_W-1:0] douta,
   output logic              idle
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_OCC = (CW+1)'(RSP_DEPTH);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t                           req_in;
   req_t                           port_q;
   logic                           accept;
   logic                           push;
   logic                           pop;
   logic [1:0]                     vld_pipe;   // [0] = s1 read on port, [1] = s2 douta valid
   logic [CW-1:0]                  fifo_count;
   logic [PW-1:0]                  wr_ptr;
   logic [PW-1:0]                  rd_ptr;
   logic [RSP_DEPTH-1:0][DATA_W-1:0] fifo_mem;
   logic [CW:0]                    occupancy;

   assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata};
   assign accept = req_valid & req_ready;

   // Buffered responses plus reads still in the pipe; admitting only below depth
   // guarantees every read lands in a free FIFO slot.
   assign occupancy = {1'b0, fifo_count}
                    + {{CW{1'b0}}, vld_pipe[0]}
                    + {{CW{1'b0}}, vld_pipe[1]};
   assign req_ready = occupancy < DEPTH_OCC;

   // Memory port: ena pulses for one cycle per accept, the rest holds.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         ena    <= 1'b0;
         port_q <= '0;
      end else begin
         ena <= accept;
         if (accept) port_q <= req_in;
      end
   end

   assign wea   = port_q.we;
   assign addra = port_q.addr;
   assign dina  = port_q.wdata;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) vld_pipe <= '0;
      else      vld_pipe <= {vld_pipe[0], accept & ~req_we};
   end

   assign push = vld_pipe[1];
   assign pop  = rsp_valid & rsp_ready;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         fifo_mem <= '0;
      end else if (push) begin
         fifo_mem[wr_ptr] <= douta;
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign rsp_valid = fifo_count != '0;
   assign rsp_rdata = fifo_mem[rd_ptr];
   assign idle      = (vld_pipe == 2'b00) & (fifo_count == '0);

endmodule

// File: tb/tb_mem_port_master.sv
// Scoreboard bench for mem_port_master: directed scenarios plus random traffic
// against a reference memory, with a separate monitor checking the port and responses.
module tb_mem_port_master;
   localparam int AW = 14;
   localparam int DW = 64;
   localparam int DEPTH = 4;

   logic          clka = 1'b0;
   logic          rsta;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ena, wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic [DW-1:0] douta;
   logic          idle;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] ram     [0:(1<<AW)-1];

   mem_port_master #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
      .clka(clka), .rsta(rsta),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
      .idle(idle)
   );

   always #5 clka = ~clka;

   // Behavioural synchronous RAM on the far side of the port.
   always @(posedge clka) begin
      if (ena) begin
         if (wea) ram[addra] <= dina;
         else     douta <= ram[addra];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected port contents: the last accepted request, ena only right after an accept.
   logic          acc_d, we_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wd_d;
   always @(posedge clka or posedge rsta) begin
      if (rsta) begin
         acc_d <= 1'b0; we_d <= 1'b0; addr_d <= '0; wd_d <= '0;
      end else begin
         acc_d <= req_valid && req_ready;
         if (req_valid && req_ready) begin
            we_d <= req_we; addr_d <= req_addr; wd_d <= req_wdata;
         end
      end
   end

   logic [DW-1:0] mon_e;
   always @(negedge clka) begin
      if (!rsta) begin
         chk("port_ena",   64'(ena),   64'(acc_d));
         chk("port_wea",   64'(wea),   64'(we_d));
         chk("port_addra", 64'(addra), 64'(addr_d));
         chk("port_dina",  dina,       wd_d);
         if (rsp_valid && exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got %h with no read outstanding", rsp_rdata);
         end else if (rsp_valid && rsp_ready) begin
            mon_e = exp_q.pop_front();
            chk("rsp_data", rsp_rdata, mon_e);
         end
         chk("outstanding_bound", 64'(exp_q.size() <= DEPTH), 64'd1);
      end
   end

   // One cycle of stimulus; on acceptance the reference model is updated.
   task automatic issue(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rr, output bit acc);
      @(posedge clka); #1;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
      @(negedge clka);
      acc = v && req_ready;
      if (acc) begin
         if (we) ref_mem[a] = d;
         else    exp_q.push_back(ref_mem[a]);
      end
   endtask

   initial begin
      bit            acc;
      int            n_acc;
      bit            v, we, rr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      rsta = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; rsp_ready = 1'b0;
      #2 rsta = 1'b1;
      #1;
      chk("rst_ena",       64'(ena),       64'd0);
      chk("rst_wea",       64'(wea),       64'd0);
      chk("rst_addra",     64'(addra),     64'd0);
      chk("rst_dina",      dina,           64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata,      64'd0);
      chk("rst_idle",      64'(idle),      64'd1);
      @(negedge clka); @(negedge clka);
      #2 rsta = 1'b0;
      #1 chk("rst_req_ready", 64'(req_ready), 64'd1);

      // Preload the address window used by all reads.
      for (int i = 0; i < 64; i++) begin
         issue(1'b1, 1'b1, AW'(i), {$urandom, $urandom}, 1'b1, acc);
         chk("preload_acc", 64'(acc), 64'd1);
      end

      // Single write: one-cycle write pulse, never a response.
      issue(1'b1, 1'b1, 14'h0005, 64'hDEADBEEF_00000001, 1'b1, acc);
      chk("wr_acc", 64'(acc), 64'd1);
      issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("wr_ena",   64'(ena),   64'd1);
      chk("wr_wea",   64'(wea),   64'd1);
      chk("wr_addra", 64'(addra), 64'h5);
      chk("wr_dina",  dina,       64'hDEADBEEF_00000001);
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
         chk("wr_ena_off",   64'(ena),       64'd0);
         chk("wr_no_rsp",    64'(rsp_valid), 64'd0);
      end

      // Read back: port read one cycle after accept, data two edges after accept.
      issue(1'b1, 1'b0, 14'h0005, '0, 1'b1, acc);
      chk("rd_acc", 64'(acc), 64'd1);
      issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("rd_ena",   64'(ena),       64'd1);
      chk("rd_wea",   64'(wea),       64'd0);
      chk("rd_addra", 64'(addra),     64'h5);
      chk("rd_lat0",  64'(rsp_valid), 64'd0);
      issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("rd_lat1",  64'(rsp_valid), 64'd0);
      issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("rd_lat2",  64'(rsp_valid), 64'd1);
      chk("rd_data",  rsp_rdata,      64'hDEADBEEF_00000001);

      // Back-to-back reads: no stall, responses on consecutive cycles.
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b0, AW'(16 + i), '0, 1'b1, acc);
         chk("b2b_ready", 64'(acc), 64'd1);
      end
      for (int k = 0; k < 4; k++) begin
         issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
         chk("b2b_rsp_valid", 64'(rsp_valid), 64'(k < 3));
      end

      // Backpressure: only DEPTH reads admitted while the consumer stalls.
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         issue(1'b1, 1'b0, AW'(32 + i), '0, 1'b0, acc);
         if (acc) n_acc++;
      end
      chk("bp_accepts",   64'(n_acc),     64'(DEPTH));
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      for (int k = 0; k < 8; k++) issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("bp_drained",   64'(exp_q.size()), 64'd0);
      chk("bp_ready_re",  64'(req_ready),    64'd1);
      chk("bp_idle",      64'(idle),         64'd1);

      // Reset with two reads in flight and one buffered.
      issue(1'b1, 1'b0, 14'h0007, '0, 1'b0, acc);
      issue(1'b1, 1'b0, 14'h0008, '0, 1'b0, acc);
      issue(1'b1, 1'b0, 14'h0009, '0, 1'b0, acc);
      @(posedge clka); #1;
      req_valid = 1'b0;
      chk("mid_pre_valid", 64'(rsp_valid), 64'd1);
      chk("mid_pre_ena",   64'(ena),       64'd1);
      chk("mid_pre_idle",  64'(idle),      64'd0);
      #1 rsta = 1'b1;
      #1;
      chk("mid_rst_ena",   64'(ena),       64'd0);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_rdata", rsp_rdata,      64'd0);
      chk("mid_rst_idle",  64'(idle),      64'd1);
      exp_q.delete();
      @(negedge clka); @(negedge clka);
      #2 rsta = 1'b0;
      #1 chk("mid_rel_ready", 64'(req_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
         chk("mid_no_stale", 64'(rsp_valid), 64'd0);
      end

      // Random mixed traffic with random consumer stalls.
      for (int i = 0; i < 10000; i++) begin
         v  = $urandom_range(0, 3) != 0;
         we = $urandom_range(0, 1) != 0;
         rr = $urandom_range(0, 2) != 0;
         a  = AW'($urandom_range(0, 63));
         d  = {$urandom, $urandom};
         issue(v, we, a, d, rr, acc);
      end
      for (int k = 0; k < 12; k++) issue(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_idle",    64'(idle),         64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
